// File: rtl/sound_event_detector_if.sv
// Bundle of sample inputs, thresholds, controls and event outputs for sound_event_detector.
// ts_out exists only when EVENT_TIMESTAMP_EN is defined.
interface sound_event_detector_if #(
  parameter int CH = 2,
  parameter int DW = 32,
  parameter int CW = 8,
  parameter int TW = 16
);
  logic [CH*DW-1:0] data_in;
  logic [CH-1:0]    data_valid;
  logic [DW-1:0]    thr_hi;
  logic [DW-1:0]    thr_lo;
  logic [15:0]      holdoff;
  logic             clr_cnt;

  logic [CH*CW-1:0] event_cnt;
  logic [CH-1:0]    event_state;
  logic [CH-1:0]    event_pulse;
  logic [2:0]       first_ch;
  logic             first_valid;
`ifdef EVENT_TIMESTAMP_EN
  logic [CH*TW-1:0] ts_out;
`else
  localparam int unused_tw = TW;
`endif

  modport master (
    output data_in, data_valid, thr_hi, thr_lo, holdoff, clr_cnt,
    input  event_cnt, event_state, event_pulse, first_ch, first_valid
`ifdef EVENT_TIMESTAMP_EN
    , input ts_out
`endif
  );

  modport slave (
    input  data_in, data_valid, thr_hi, thr_lo, holdoff, clr_cnt,
    output event_cnt, event_state, event_pulse, first_ch, first_valid
`ifdef EVENT_TIMESTAMP_EN
    , output ts_out
`endif
  );
endinterface

// File: rtl/sound_event_detector.sv
// Per-channel IDLE/ACTIVE hysteresis detector with hold-off, saturating event counters and a
// first-channel latch. Defining EVENT_TIMESTAMP_EN adds a free-running counter and per-channel ts_out.
module sound_event_detector #(
  parameter int CH = 2,
  parameter int DW = 32,
  parameter int CW = 8,
  parameter int TW = 16
) (
  input logic                    clk,
  input logic                    rstn_in,
  sound_event_detector_if.slave  bus
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_ACTIVE = 1'b1;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic [CH-1:0]    pulse_vec;
  logic [CH-1:0]    state_vec;
  logic [CH*CW-1:0] cnt_vec;
  logic [2:0]       first_ch_reg;
  logic [2:0]       first_ch_next;
  logic [2:0]       first_idx;
  logic             first_valid_reg;
  logic             first_valid_next;

`ifdef EVENT_TIMESTAMP_EN
  logic [TW-1:0]    ts_cnt_reg;
  logic [CH*TW-1:0] ts_vec;

  always_ff @(posedge clk) begin
    if (!rstn_in) begin
      ts_cnt_reg <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 1'b1;
    end
  end

  assign bus.ts_out = ts_vec;
`else
  localparam int unused_tw = TW;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [DW-1:0] sample;
      logic [0:0]    state_reg;
      logic [0:0]    state_next;
      logic [15:0]   hold_reg;
      logic [15:0]   hold_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          pulse_reg;
      logic          rise;

      assign sample = bus.data_in[gi*DW +: DW];

      // Transitions are only evaluated on a valid sample; a blocked rise simply retries next sample.
      always_comb begin
        state_next = state_reg;
        rise       = 1'b0;
        if (bus.data_valid[gi]) begin
          if (state_reg == ST_IDLE) begin
            if ((sample >= bus.thr_hi) && (hold_reg == 16'd0)) begin
              state_next = ST_ACTIVE;
              rise       = 1'b1;
            end
          end else if (sample <= bus.thr_lo) begin
            state_next = ST_IDLE;
          end
        end
      end

      // Hold-off runs every clock, not just on valid samples.
      always_comb begin
        hold_next = hold_reg;
        if (rise) begin
          hold_next = bus.holdoff;
        end else if (hold_reg != 16'd0) begin
          hold_next = hold_reg - 16'd1;
        end
      end

      always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr_cnt) begin
          cnt_next = '0;
        end else if (rise && (cnt_reg != CNT_MAX)) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn_in) begin
          state_reg <= ST_IDLE;
          hold_reg  <= '0;
          cnt_reg   <= '0;
          pulse_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          hold_reg  <= hold_next;
          cnt_reg   <= cnt_next;
          pulse_reg <= rise;
        end
      end

`ifdef EVENT_TIMESTAMP_EN
      logic [TW-1:0] ts_reg;

      always_ff @(posedge clk) begin
        if (!rstn_in) begin
          ts_reg <= '0;
        end else if (rise) begin
          ts_reg <= ts_cnt_reg;
        end
      end

      assign ts_vec[gi*TW +: TW] = ts_reg;
`endif

      assign pulse_vec[gi]          = pulse_reg;
      assign state_vec[gi]          = (state_reg == ST_ACTIVE);
      assign cnt_vec[gi*CW +: CW]   = cnt_reg;
    end
  endgenerate

  assign bus.event_pulse = pulse_vec;
  assign bus.event_state = state_vec;
  assign bus.event_cnt   = cnt_vec;

  // Scan downward so the lowest pulsing channel wins.
  always_comb begin
    first_idx = 3'd0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (pulse_vec[i]) begin
        first_idx = 3'(i);
      end
    end
  end

  always_comb begin
    first_ch_next    = first_ch_reg;
    first_valid_next = first_valid_reg;
    if (bus.clr_cnt) begin
      first_ch_next    = 3'd0;
      first_valid_next = 1'b0;
    end else if (!first_valid_reg && (|pulse_vec)) begin
      first_ch_next    = first_idx;
      first_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_in) begin
      first_ch_reg    <= 3'd0;
      first_valid_reg <= 1'b0;
    end else begin
      first_ch_reg    <= first_ch_next;
      first_valid_reg <= first_valid_next;
    end
  end

  assign bus.first_ch    = first_ch_reg;
  assign bus.first_valid = first_valid_reg;

endmodule

// File: tb/tb_sound_event_detector.sv
// Bench for sound_event_detector: directed table, hand-written corner sequences and a
// randomized run against an event-level reference model. Timestamp checks need EVENT_TIMESTAMP_EN.
module tb_sound_event_detector;
  localparam int CH   = 2;
  localparam int DW   = 16;
  localparam int CW   = 2;
  localparam int TW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #10 clk = ~clk;

  sound_event_detector_if #(.CH(CH), .DW(DW), .CW(CW), .TW(TW)) bus ();

  sound_event_detector #(.CH(CH), .DW(DW), .CW(CW), .TW(TW)) dut (
    .clk     (clk),
    .rstn_in (rstn),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event-level view (last event cycle vs hold-off, saturating integer counts).
  int m_active [CH];
  int m_cnt    [CH];
  int m_pulse  [CH];
  int m_has_ev [CH];
  int m_last   [CH];
  int m_hold   [CH];
  int m_ts     [CH];
  int m_first;
  int m_ts_cnt;
  int cyc;

  typedef struct {
    bit       rstn;
    bit       clr;
    bit [1:0] valid;
    int       d0;
    int       d1;
    bit [1:0] st;
    bit [1:0] pu;
    int       c0;
    int       c1;
    bit       fv;
    int       fch;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit [1:0] v, input int d0, input int d1);
    rstn           = r;
    bus.clr_cnt    = c;
    bus.data_valid = v;
    bus.data_in    = {DW'(d1), DW'(d0)};
  endtask

  task automatic model_edge();
    int low;
    int d;
    int ev;
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        m_active[i] = 0; m_cnt[i] = 0; m_pulse[i] = 0;
        m_has_ev[i] = 0; m_ts[i] = 0;
      end
      m_first  = -1;
      m_ts_cnt = 0;
    end else begin
      low = -1;
      for (int i = CH - 1; i >= 0; i--) if (m_pulse[i] != 0) low = i;
      for (int i = 0; i < CH; i++) begin
        ev = 0;
        if (bus.data_valid[i]) begin
          d = int'(bus.data_in[i*DW +: DW]);
          if (m_active[i] != 0) begin
            if (d <= int'(bus.thr_lo)) m_active[i] = 0;
          end else if (d >= int'(bus.thr_hi) &&
                       (m_has_ev[i] == 0 || (cyc - m_last[i]) > m_hold[i])) begin
            m_active[i] = 1;
            ev          = 1;
            m_has_ev[i] = 1;
            m_last[i]   = cyc;
            m_hold[i]   = int'(bus.holdoff);
            m_ts[i]     = m_ts_cnt;
          end
        end
        m_pulse[i] = ev;
        if (bus.clr_cnt) m_cnt[i] = 0;
        else if (ev != 0 && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
      if (bus.clr_cnt) m_first = -1;
      else if (m_first < 0 && low >= 0) m_first = low;
      m_ts_cnt = (m_ts_cnt + 1) % (1 << TW);
    end
    cyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [CH-1:0]    est;
    logic [CH-1:0]    epu;
    logic [CH*CW-1:0] ecnt;
    for (int i = 0; i < CH; i++) begin
      est[i]            = (m_active[i] != 0);
      epu[i]            = (m_pulse[i] != 0);
      ecnt[i*CW +: CW]  = CW'(m_cnt[i]);
    end
    check("rnd_state", bus.event_state, est);
    check("rnd_pulse", bus.event_pulse, epu);
    check("rnd_cnt", bus.event_cnt, ecnt);
    check("rnd_first_valid", bus.first_valid, (m_first >= 0));
    check("rnd_first_ch", bus.first_ch, (m_first >= 0) ? m_first : 0);
`ifdef EVENT_TIMESTAMP_EN
    for (int i = 0; i < CH; i++) check($sformatf("rnd_ts%0d", i), bus.ts_out[i*TW +: TW], m_ts[i]);
`endif
  endtask

  initial begin
    int npulse;
    cyc = 0;
    m_first = -1;
    m_ts_cnt = 0;
    bus.thr_hi  = DW'(550);
    bus.thr_lo  = DW'(250);
    bus.holdoff = 16'd0;
    drive(1'b0, 1'b0, 2'b00, 0, 0);

    //            rstn clr valid  d0   d1   st     pu     c0 c1 fv fch
    tbl[0]  = '{1'b0, 1'b0, 2'b00,   0,   0, 2'b00, 2'b00, 0, 0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 2'b01, 100,   0, 2'b00, 2'b00, 0, 0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 2'b01, 600,   0, 2'b01, 2'b01, 1, 0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 400,   0, 2'b01, 2'b00, 1, 0, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 2'b01, 700,   0, 2'b01, 2'b00, 1, 0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 2'b01, 200,   0, 2'b00, 2'b00, 1, 0, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 600,   0, 2'b01, 2'b01, 2, 0, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b0, 2'b10,   0, 600, 2'b11, 2'b10, 2, 1, 1'b1, 0};
    tbl[8]  = '{1'b1, 1'b0, 2'b11, 100, 900, 2'b10, 2'b00, 2, 1, 1'b1, 0};
    tbl[9]  = '{1'b1, 1'b1, 2'b01, 800,   0, 2'b11, 2'b01, 0, 0, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b0, 2'b00,   0,   0, 2'b11, 2'b00, 0, 0, 1'b1, 0};
    tbl[11] = '{1'b1, 1'b1, 2'b11,   0,   0, 2'b00, 2'b00, 0, 0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 2'b11, 600, 600, 2'b11, 2'b11, 1, 1, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0, 2'b00,   0,   0, 2'b11, 2'b00, 1, 1, 1'b1, 0};
    tbl[14] = '{1'b1, 1'b1, 2'b00,   0,   0, 2'b11, 2'b00, 0, 0, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 2'b10,   0,   0, 2'b01, 2'b00, 0, 0, 1'b0, 0};
    tbl[16] = '{1'b1, 1'b0, 2'b10,   0, 600, 2'b11, 2'b10, 0, 1, 1'b0, 0};
    tbl[17] = '{1'b1, 1'b0, 2'b00,   0,   0, 2'b11, 2'b00, 0, 1, 1'b1, 1};

    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].rstn, tbl[r].clr, tbl[r].valid, tbl[r].d0, tbl[r].d1);
      step();
      check($sformatf("row%0d_state", r), bus.event_state, tbl[r].st);
      check($sformatf("row%0d_pulse", r), bus.event_pulse, tbl[r].pu);
      check($sformatf("row%0d_cnt0", r), bus.event_cnt[CW-1:0], tbl[r].c0);
      check($sformatf("row%0d_cnt1", r), bus.event_cnt[2*CW-1:CW], tbl[r].c1);
      check($sformatf("row%0d_first_valid", r), bus.first_valid, tbl[r].fv);
      check($sformatf("row%0d_first_ch", r), bus.first_ch, tbl[r].fch);
    end

    // Saturation: five events on ch1 with a 2-bit counter.
    drive(1'b1, 1'b1, 2'b10, 0, 0);
    step();
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 2'b10, 0, 600);
      step();
      if (bus.event_pulse[1]) npulse++;
      drive(1'b1, 1'b0, 2'b10, 0, 0);
      step();
    end
    check("sat_cnt1", bus.event_cnt[2*CW-1:CW], 3);
    check("sat_pulses", npulse, 5);

    // Hold-off of 100: crossings at t, t+40 (blocked) and t+150 (counted).
    bus.holdoff = 16'd100;
    drive(1'b1, 1'b1, 2'b01, 0, 0);
    step();
    drive(1'b1, 1'b0, 2'b01, 600, 0);
    step();
    check("hold_first_pulse", bus.event_pulse[0], 1);
    for (int k = 1; k <= 150; k++) begin
      if (k == 1) drive(1'b1, 1'b0, 2'b01, 200, 0);
      else if (k == 40 || k == 150) drive(1'b1, 1'b0, 2'b01, 600, 0);
      else drive(1'b1, 1'b0, 2'b00, 0, 0);
      step();
      if (k == 40) begin
        check("hold_blocked_pulse", bus.event_pulse[0], 0);
        check("hold_blocked_state", bus.event_state[0], 0);
      end
      if (k == 150) begin
        check("hold_late_pulse", bus.event_pulse[0], 1);
        check("hold_cnt0", bus.event_cnt[CW-1:0], 2);
      end
    end

    // Reset while ch0 is ACTIVE with hold-off running and a pulse pending.
    drive(1'b0, 1'b0, 2'b00, 0, 0);
    step();
    check("rst_state", bus.event_state, 0);
    check("rst_pulse", bus.event_pulse, 0);
    check("rst_cnt", bus.event_cnt, 0);
    check("rst_first_valid", bus.first_valid, 0);
    check("rst_first_ch", bus.first_ch, 0);
`ifdef EVENT_TIMESTAMP_EN
    check("rst_ts", bus.ts_out, 0);
`endif
    drive(1'b1, 1'b0, 2'b01, 600, 0);
    step();
    check("rst_after_pulse", bus.event_pulse[0], 1);
    check("rst_after_state", bus.event_state[0], 1);

`ifdef EVENT_TIMESTAMP_EN
    // Timestamp capture at counter value 15, then again after wrap at 2.
    bus.holdoff = 16'd0;
    drive(1'b1, 1'b0, 2'b01, 0, 0);
    step();
    for (int k = 0; k < 20 && m_ts_cnt != 15; k++) begin
      drive(1'b1, 1'b0, 2'b00, 0, 0);
      step();
    end
    drive(1'b1, 1'b0, 2'b01, 600, 0);
    step();
    check("ts_at_15", bus.ts_out[TW-1:0], 15);
    drive(1'b1, 1'b0, 2'b01, 0, 0);
    step();
    for (int k = 0; k < 20 && m_ts_cnt != 2; k++) begin
      drive(1'b1, 1'b0, 2'b00, 0, 0);
      step();
    end
    drive(1'b1, 1'b0, 2'b01, 600, 0);
    step();
    check("ts_at_2", bus.ts_out[TW-1:0], 2);
`endif

    // Randomized run against the model, including thr_lo >= thr_hi and sporadic clear/reset.
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) begin
        bus.thr_hi  = DW'($urandom_range(300, 700));
        bus.thr_lo  = DW'($urandom_range(100, 800));
        bus.holdoff = 16'($urandom_range(0, 12));
      end
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
            2'($urandom_range(0, 3)), int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)));
      step();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
